// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shifter: default width, FSM states and type codes.
// Build option: define SEQ_SHIFTER_ROTATE_EN to enable rotate support in seq_shifter.
package seq_shifter_pkg;

    localparam int SEQ_SHIFTER_WIDTH = 16;

    localparam logic SHIFT_LOGICAL = 1'b1;
    localparam logic SHIFT_ARITH   = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-bit shift of an operand, left or right, logical or arithmetic.
// With SEQ_SHIFTER_ROTATE_EN defined, an extra rotate input recirculates the outgoing bit.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = SEQ_SHIFTER_WIDTH
) (
    input  logic [WIDTH-1:0] i_operand,
    input  logic             i_right,
    input  logic             i_type,
`ifdef SEQ_SHIFTER_ROTATE_EN
    input  logic             i_rotate,
`endif
    output logic [WIDTH-1:0] o_result
);

    logic w_fill;

    always_comb begin
        w_fill = 1'b0;
        if (i_right && (i_type == SHIFT_ARITH)) begin
            w_fill = i_operand[WIDTH-1];
        end
`ifdef SEQ_SHIFTER_ROTATE_EN
        if (i_rotate) begin
            w_fill = i_right ? i_operand[0] : i_operand[WIDTH-1];
        end
`endif
        o_result = i_right ? {w_fill, i_operand[WIDTH-1:1]}
                           : {i_operand[WIDTH-2:0], w_fill};
    end

endmodule

// File: rtl/seq_shifter.sv
// Sequential barrel-free shifter: moves the operand one bit per clock, pulses done on completion.
// Build option: SEQ_SHIFTER_ROTATE_EN adds the shiftRotate input and rotate behaviour.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = SEQ_SHIFTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] shiftDirection,
    input  logic             shiftType,
`ifdef SEQ_SHIFTER_ROTATE_EN
    input  logic             shiftRotate,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shiftOut
);

    localparam logic [WIDTH-1:0] W_MAX = WIDTH'(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_count;
    logic             r_right;
    logic             r_type;
    logic [WIDTH-1:0] r_shift_out;
`ifdef SEQ_SHIFTER_ROTATE_EN
    logic             r_rotate;
`endif

    logic [WIDTH-1:0] w_mag;
    logic [WIDTH-1:0] w_n;
    logic [WIDTH-1:0] w_step;

    // Magnitude of the most negative amount is 2^(WIDTH-1), which still fits unsigned.
    assign w_mag = shiftDirection[WIDTH-1] ? (-shiftDirection) : shiftDirection;

    always_comb begin
        w_n = (w_mag > W_MAX) ? W_MAX : w_mag;
`ifdef SEQ_SHIFTER_ROTATE_EN
        if (shiftRotate) begin
            w_n = w_mag % W_MAX;
        end
`endif
    end

    shift_step #(
        .WIDTH     (WIDTH)
    ) u_shift_step (
        .i_operand (r_work),
        .i_right   (r_right),
        .i_type    (r_type),
`ifdef SEQ_SHIFTER_ROTATE_EN
        .i_rotate  (r_rotate),
`endif
        .o_result  (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_count     <= '0;
            r_right     <= 1'b0;
            r_type      <= 1'b0;
            r_shift_out <= '0;
`ifdef SEQ_SHIFTER_ROTATE_EN
            r_rotate    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work  <= src;
                        r_right <= shiftDirection[WIDTH-1];
                        r_type  <= shiftType;
                        r_count <= w_n;
`ifdef SEQ_SHIFTER_ROTATE_EN
                        r_rotate <= shiftRotate;
`endif
                        if (w_n == '0) begin
                            r_shift_out <= src;
                            r_state     <= DONE;
                        end else begin
                            r_state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_work  <= w_step;
                    r_count <= r_count - WIDTH'(1);
                    // Publish on the final step so done and shiftOut appear together.
                    if (r_count == WIDTH'(1)) begin
                        r_shift_out <= w_step;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state == SHIFT);
    assign done     = (r_state == DONE);
    assign shiftOut = r_shift_out;

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-005 SHALL have port src, input, WIDTH, operand; captured when start is accepted.
REQ-006 SHALL have port shiftDirection, input, WIDTH, signed two's-complement amount: positive = left, negative = right, zero = none.
REQ-007 SHALL have port shiftType, input, 1, 1 = logical, 0 = arithmetic; captured with src.
REQ-008 SHALL have port busy, output, 1, high in SHIFT state.
REQ-009 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port shiftOut, output, WIDTH, last completed result.

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-012 On the edge E0 that samples start=1 in IDLE, SHALL capture src into a working register, shiftType, the direction (sign bit) and n = min(|shiftDirection|, WIDTH), with |-2^(WIDTH-1)| clamped to WIDTH.
REQ-013 When n=0, SHALL go IDLE->DONE on E0; otherwise IDLE->SHIFT on E0.
REQ-014 In SHIFT, each edge SHALL move the working register one bit and decrement the count; on the edge where the count reaches 0, SHALL go SHIFT->DONE.
REQ-015 A left shift SHALL fill the LSB with 0 for both types, so arithmetic left equals logical left.
REQ-016 A logical right shift SHALL fill the MSB with 0; an arithmetic right shift SHALL replicate the captured MSB.
REQ-017 In DONE, SHALL drive done=1 for exactly one cycle, load shiftOut from the working register, and return to IDLE on the next edge.
REQ-018 done SHALL therefore rise on edge E0+n; shiftOut SHALL equal src for n=0.
REQ-019 shiftOut SHALL hold its value from completion until the next completion; intermediate values SHALL never appear on it.
REQ-020 start while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 Input changes after E0 SHALL NOT affect the operation in flight.
REQ-022 n=WIDTH SHALL yield all zeros for a left or logical right shift, and all copies of the sign bit for an arithmetic right shift.

Reset
REQ-023 rst_n=0 SHALL force, asynchronously, state=IDLE, shiftOut=0, busy=0, done=0, count=0 and working register=0.
REQ-024 Reset during SHIFT SHALL abort the operation; no done pulse SHALL follow release.
REQ-025 The first start SHALL be accepted on the first edge after rst_n deasserts.

Configuration
REQ-026 With SEQ_SHIFTER_ROTATE_EN defined, SHALL add input shiftRotate (1 bit), captured at E0.
REQ-027 When shiftRotate=1, SHALL rotate: the bit shifted out re-enters the opposite end, shiftType is ignored, and n = |shiftDirection| mod WIDTH.
REQ-028 Without SEQ_SHIFTER_ROTATE_EN, the shiftRotate port and rotate logic SHALL be absent, with behaviour as REQ-011..022.

Structure
REQ-029 Package seq_shifter_pkg SHALL hold the WIDTH default, the FSM state enum, and the constants SHIFT_LOGICAL=1 and SHIFT_ARITH=0.
REQ-030 SHALL instantiate one sub-module, shift_step: combinational one-bit step taking operand, direction, type and (optionally) rotate.

Verification
REQ-031 rst_n low: shiftOut=0000, busy=0, done=0; after release, no activity without start.
REQ-032 src=FFFF, shiftDirection=FFFF, shiftType=1: done on E0+1, shiftOut=7FFF.
REQ-033 src=8000, shiftDirection=FFFC, shiftType=0: busy for 4 cycles, done on E0+4, shiftOut=F800; then shiftDirection=0001: shiftOut=0000.
REQ-034 Zero and clamped amounts:
- src=1234, shiftDirection=0000: done on E0, shiftOut=1234.
- src=0001, shiftDirection=0014, logical: done on E0+16, shiftOut=0000.
REQ-035 start pulsed mid-operation with different src: ignored, and the first result is unchanged; with SEQ_SHIFTER_ROTATE_EN, src=8001, shiftDirection=0001, rotate: shiftOut=0003.
REQ-036 rst_n asserted at E0+2 of a 10-bit shift: shiftOut=0000 and no done pulse; a following start completes normally.
